dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Shares the single-port data memory (dm) between the pipeline CPU's MEM-stage access and a debug/loader requester, for example a UART program loader or a bench backdoor.
- CPU has fixed priority.
- A starvation counter guarantees the debug port a slot within MAX_WAIT contended cycles.
- When the debug port wins, the CPU is stalled for one cycle.
- Sits in comp between U_CPU and U_DM.

Parameters:
MAX_WAIT, 4, max consecutive cycles a pending debug request may lose to a CPU access before a forced grant; 0 = grant on the next cycle unconditionally
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
cpu_req  input  1  CPU MEM stage has a load/store this cycle
cpu_we  input  1  CPU write enable (MemWrite)
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU store data
cpu_dmtype  input  3  CPU DMType
cpu_rdata  output  DW  load data to CPU (= dm_dout)
cpu_stall  output  1  CPU access not performed this cycle; hold MEM stage
dbg_req  input  1  debug request; fields stable while high until ack
dbg_we  input  1  debug write enable
dbg_addr  input  AW  debug address
dbg_wdata  input  DW  debug write data
dbg_dmtype  input  3  debug DMType
dbg_ack  output  1  one-cycle completion pulse
dbg_rdata  output  DW  registered debug read data
dm_we  output  1  to dm DMWr
dm_addr  output  AW  to dm addr
dm_din  output  DW  to dm din
dm_dmtype  output  3  to dm DMType
dm_dout  input  DW  from dm dout (combinational read)

Behaviour:
- Reset: clk rising edge with rstn=0. Takes priority in any state, including mid-access.
  - state<=OWN_CPU, wait_cnt<=0, dbg_ack<=0, dbg_rdata<=0.
  - Outputs then: mux selects CPU, cpu_stall=0.
- FSM states: OWN_CPU, DBG_ACCESS, DBG_DONE. Encoding comes from the package.
- OWN_CPU:
  - dm_* = cpu_*.
  - cpu_stall=0, dbg_ack=0.
  - If dbg_req && (!cpu_req || wait_cnt==MAX_WAIT): next=DBG_ACCESS, wait_cnt<=0.
  - Else if dbg_req && cpu_req: wait_cnt<=wait_cnt+1, saturating at MAX_WAIT.
  - Else if !dbg_req: wait_cnt<=0.
- DBG_ACCESS (exactly 1 cycle):
  - dm_* = dbg_*.
  - cpu_stall=cpu_req. The CPU access is not performed and dm_we never reflects cpu_we.
  - If !dbg_we: dbg_rdata<=dm_dout. On writes dbg_rdata holds.
  - next=DBG_DONE.
- DBG_DONE (exactly 1 cycle):
  - dm_* = cpu_*, cpu_stall=0, dbg_ack=1.
  - dbg_req is ignored this cycle. The requester must drop req at this edge, or it is treated as a new request in OWN_CPU.
  - next=OWN_CPU.
- Debug access latency:
  - Uncontended: 2 cycles from req sampled to ack high.
  - Worst case: MAX_WAIT+2.
- cpu_rdata = dm_dout in all states. It is meaningful only when cpu_stall=0.
- cpu_stall is combinational from state and cpu_req. dbg_ack is a registered-state decode and is glitch-free.
- At most one dm write per cycle, always from the owner selected by state.
- wait_cnt width = $clog2(MAX_WAIT+1), minimum 1 bit.
- Reset mid-DBG_ACCESS: no ack is issued. dbg_rdata is cleared to 0. The requester must re-request.

Decomposition:
- Shared package: FSM state enum (OWN_CPU, DBG_ACCESS, DBG_DONE) and DMType constants (byte/half/word, signed/unsigned), shared with dm.
- No sub-module. Counter and FSM fit in one module, approx. 150 lines.

Test Plan:
- Reset: rstn=0 for 2 cycles with dbg_req=1 and cpu_req=1 → dbg_ack=0, dbg_rdata=0, cpu_stall=0, dm_addr=cpu_addr.
- Uncontended debug write/read:
  - Write: cpu_req=0, dbg write addr 0x40 data 0xDEADBEEF word → dm_we=1 in DBG_ACCESS, ack in the following cycle.
  - Read back: dbg_rdata=0xDEADBEEF on ack, with no cpu_stall at any time.
- Starvation: cpu_req=1 continuously, dbg_req raised at cycle t, MAX_WAIT=4 → cpu_stall=1 exactly at cycle t+5, dbg_ack at t+6, cpu_stall=0 otherwise.
- Contended write ordering:
  - CPU store of 0x11111111 to 0x80 is stalled in DBG_ACCESS while debug writes 0x22222222 to 0x80.
  - The CPU re-presents the store afterwards, so the final dm[0x80]=0x11111111.
- Held req: dbg_req kept high through ack with cpu_req=0 → a second access starts one cycle after DBG_DONE, giving acks 3 cycles apart.
- Reset mid-op: rstn=0 during DBG_ACCESS → next cycle state OWN_CPU, dbg_ack stays 0, dbg_rdata=0, no spurious dm_we from the debug port.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership FSM states and the
// DMType access-size codes that the data memory also decodes.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_CPU    = 2'd0,
        DBG_ACCESS = 2'd1,
        DBG_DONE   = 2'd2
    } dm_arb_state_e;

    localparam int DMTYPE_W = 3;

    localparam logic [DMTYPE_W-1:0] DM_WORD              = 3'b000;
    localparam logic [DMTYPE_W-1:0] DM_HALFWORD          = 3'b001;
    localparam logic [DMTYPE_W-1:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [DMTYPE_W-1:0] DM_BYTE              = 3'b011;
    localparam logic [DMTYPE_W-1:0] DM_BYTE_UNSIGNED     = 3'b100;

    // Width of a counter that must reach max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (fixed
// priority) and a debug/loader port that is guaranteed a slot after MAX_WAIT losses.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    input  logic [DMTYPE_W-1:0] cpu_dmtype,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_stall,

    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [DW-1:0]       dbg_wdata,
    input  logic [DMTYPE_W-1:0] dbg_dmtype,
    output logic                dbg_ack,
    output logic [DW-1:0]       dbg_rdata,

    output logic                dm_we,
    output logic [AW-1:0]       dm_addr,
    output logic [DW-1:0]       dm_din,
    output logic [DMTYPE_W-1:0] dm_dmtype,
    input  logic [DW-1:0]       dm_dout
);

    localparam int CW = cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    dm_arb_state_e   state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [DW-1:0]   dbg_rdata_reg;
    logic            dbg_owns;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= OWN_CPU;
            wait_cnt_reg  <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_reg == DBG_ACCESS && !dbg_we) begin
                dbg_rdata_reg <= dm_dout;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            OWN_CPU: begin
                if (dbg_req && (!cpu_req || wait_cnt_reg == WAIT_LIMIT)) begin
                    state_next    = DBG_ACCESS;
                    wait_cnt_next = '0;
                end else if (dbg_req) begin
                    // Lost to the CPU this cycle; count towards the forced grant.
                    if (wait_cnt_reg != WAIT_LIMIT) begin
                        wait_cnt_next = wait_cnt_reg + CW'(1);
                    end
                end else begin
                    wait_cnt_next = '0;
                end
            end
            DBG_ACCESS: state_next = DBG_DONE;
            DBG_DONE:   state_next = OWN_CPU;
            default:    state_next = OWN_CPU;
        endcase
    end

    // Debug path is masked while reset is asserted so an interrupted debug
    // access cannot write memory in the reset cycle.
    assign dbg_owns = (state_reg == DBG_ACCESS) && rstn;

    always_comb begin
        dm_we     = cpu_req & cpu_we;
        dm_addr   = cpu_addr;
        dm_din    = cpu_wdata;
        dm_dmtype = cpu_dmtype;
        if (dbg_owns) begin
            dm_we     = dbg_we;
            dm_addr   = dbg_addr;
            dm_din    = dbg_wdata;
            dm_dmtype = dbg_dmtype;
        end
    end

    assign cpu_stall = dbg_owns & cpu_req;
    assign cpu_rdata = dm_dout;
    assign dbg_ack   = (state_reg == DBG_DONE);
    assign dbg_rdata = dbg_rdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: reset, uncontended and contended debug
// accesses, starvation timing, held requests and reset during an access.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [2:0]    cpu_dmtype;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [2:0]    dbg_dmtype;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic [2:0]    dm_dmtype;
    logic [DW-1:0] dm_dout;

    logic [DW-1:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    dm_arbiter #(.MAX_WAIT(4), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_dmtype (cpu_dmtype),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_dmtype (dbg_dmtype),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dmtype  (dm_dmtype),
        .dm_dout    (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed data memory with combinational read.
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[9:2]] <= dm_din;
    end
    assign dm_dout = mem[dm_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int ack_first, ack_second, stall_cnt;
    logic found;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rstn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        cpu_wdata = '0; cpu_dmtype = DM_WORD;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; dbg_wdata = '0; dbg_dmtype = DM_WORD;

        // Reset held two cycles with both requesters active.
        step(); step(); settle();
        chk("rst_ack",   32'(dbg_ack),   32'd0);
        chk("rst_rdata", dbg_rdata,      32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_addr",  dm_addr,        32'h10);
        $display("txn reset done");
        rstn = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
        step();

        // Uncontended debug write of 0xDEADBEEF to 0x40.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hDEADBEEF;
        settle();
        chk("uw_own_we",   32'(dm_we),     32'd0);
        chk("uw_own_addr", dm_addr,        32'h10);
        step();
        chk("uw_acc_we",    32'(dm_we),     32'd1);
        chk("uw_acc_addr",  dm_addr,        32'h40);
        chk("uw_acc_din",   dm_din,         32'hDEADBEEF);
        chk("uw_acc_stall", 32'(cpu_stall), 32'd0);
        chk("uw_acc_ack",   32'(dbg_ack),   32'd0);
        step();
        chk("uw_done_ack", 32'(dbg_ack), 32'd1);
        chk("uw_done_we",  32'(dm_we),   32'd0);
        dbg_req = 1'b0;
        step();
        chk("uw_idle_ack", 32'(dbg_ack), 32'd0);
        $display("txn dbg write addr=40 data=deadbeef");

        // Uncontended read back.
        dbg_req = 1'b1; dbg_we = 1'b0;
        step();
        chk("ur_acc_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("ur_ack",   32'(dbg_ack), 32'd1);
        chk("ur_rdata", dbg_rdata,    32'hDEADBEEF);
        dbg_req = 1'b0;
        step();
        $display("txn dbg read addr=40 rdata=%h", dbg_rdata);

        // Starvation: CPU busy every cycle; stall expected at t+5, ack at t+6.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        stall_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            settle();
            chk($sformatf("sv_stall_%0d", k), 32'(cpu_stall), (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("sv_ack_%0d", k),   32'(dbg_ack),   (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) begin
                chk("sv_rdata", dbg_rdata, 32'hDEADBEEF);
                dbg_req = 1'b0;
            end
            if (cpu_stall) stall_cnt++;
            step();
        end
        chk("sv_stall_total", 32'(stall_cnt), 32'd1);
        $display("txn starvation grant stalls=%0d", stall_cnt);

        // Contended writes to 0x80: CPU store must land last.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h11111111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h80; dbg_wdata = 32'h22222222;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (cpu_stall) found = 1'b1;
            else step();
        end
        chk("cw_stall_seen", 32'(found), 32'd1);
        chk("cw_acc_din",    dm_din,     32'h22222222);
        chk("cw_acc_we",     32'(dm_we), 32'd1);
        step();
        chk("cw_done_ack",   32'(dbg_ack),   32'd1);
        chk("cw_done_stall", 32'(cpu_stall), 32'd0);
        chk("cw_dbg_landed", cpu_rdata,      32'h22222222);
        dbg_req = 1'b0;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        settle();
        chk("cw_final", mem[32'h80 >> 2], 32'h11111111);
        step();
        $display("txn contended write addr=80 final=%h", mem[32'h80 >> 2]);

        // Held request with idle CPU: acks three cycles apart.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        ack_first = -1; ack_second = -1;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (dbg_ack) begin
                if (ack_first < 0) ack_first = k;
                else if (ack_second < 0) ack_second = k;
            end
            if (k == 5) dbg_req = 1'b0;
            step();
        end
        chk("held_first",  32'(ack_first),  32'd2);
        chk("held_second", 32'(ack_second), 32'd5);
        $display("txn held req acks at %0d and %0d", ack_first, ack_second);

        // Reset asserted while a debug write is in DBG_ACCESS.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'h33333333;
        step();
        rstn = 1'b0;
        settle();
        chk("rmid_we", 32'(dm_we), 32'd0);
        step();
        chk("rmid_ack",   32'(dbg_ack), 32'd0);
        chk("rmid_rdata", dbg_rdata,    32'd0);
        chk("rmid_mem",   mem[32'h44 >> 2], 32'd0);
        rstn = 1'b1; dbg_req = 1'b0;
        step();
        chk("rmid_ack2", 32'(dbg_ack), 32'd0);
        $display("txn reset mid access done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
